// File: rtl/mc_sequencer_if.sv
// Pin-side bus of the Monte Carlo run controller: command/data in, parameters,
// datapath strobes and final price out.
interface mc_sequencer_if;
  logic [1:0]  state;
  logic [11:0] in;
  logic [15:0] price_in;
  logic        price_valid;
  logic [11:0] s0;
  logic [11:0] strike;
  logic [11:0] sigma;
  logic [11:0] n_paths;
  logic        sobol_start;
  logic        step_valid;
  logic        path_first;
  logic        path_last;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (
    output state, in, price_in, price_valid,
    input  s0, strike, sigma, n_paths, sobol_start, step_valid,
           path_first, path_last, busy, done, out
  );

  modport slave (
    input  state, in, price_in, price_valid,
    output s0, strike, sigma, n_paths, sobol_start, step_valid,
           path_first, path_last, busy, done, out
  );
endinterface

// File: rtl/mc_sequencer.sv
// Run controller: latches pricing parameters, then sequences seed, n_paths x N_STEP
// steps and drain, and captures the final price.
module mc_sequencer #(
  parameter int N_STEP = 16,
  parameter int STEP_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  mc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_SEED, ST_RUN, ST_DRAIN, ST_DONE} fsm_t;
  typedef enum logic [1:0] {CMD_NOP, CMD_LOAD, CMD_RUN, CMD_READ} cmd_t;

  fsm_t              fsm, fsm_nxt;
  cmd_t              cmd;
  logic [1:0]        ptr;
  logic [STEP_W-1:0] step;
  logic [11:0]       path;
  logic [11:0]       s0_q, strike_q, sigma_q, n_paths_q;
  logic [15:0]       out_q;
  logic              last_step, last_path;

  assign cmd       = cmd_t'(bus.state);
  assign last_step = (step == STEP_W'(N_STEP - 1));
  assign last_path = (path == n_paths_q - 12'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= ST_IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      ST_IDLE:  if (cmd == CMD_RUN) fsm_nxt = (n_paths_q != '0) ? ST_SEED : ST_DONE;
      ST_SEED:  fsm_nxt = ST_RUN;
      ST_RUN:   if (last_step && last_path) fsm_nxt = ST_DRAIN;
      ST_DRAIN: if (bus.price_valid) fsm_nxt = ST_DONE;
      ST_DONE:  if (cmd == CMD_NOP) fsm_nxt = ST_IDLE;
      default:  fsm_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.sobol_start = (fsm == ST_SEED);
    bus.step_valid  = (fsm == ST_RUN);
    bus.path_first  = (fsm == ST_RUN) && (step == '0);
    bus.path_last   = (fsm == ST_RUN) && last_step;
    bus.busy        = (fsm == ST_SEED) || (fsm == ST_RUN) || (fsm == ST_DRAIN);
    bus.done        = (fsm == ST_DONE);
  end

  // Commands are only decoded in IDLE, so parameters are frozen for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      step      <= '0;
      path      <= '0;
      s0_q      <= '0;
      strike_q  <= '0;
      sigma_q   <= '0;
      n_paths_q <= '0;
      out_q     <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (cmd == CMD_LOAD) begin
            case (ptr)
              2'd0:    s0_q      <= bus.in;
              2'd1:    strike_q  <= bus.in;
              2'd2:    sigma_q   <= bus.in;
              default: n_paths_q <= bus.in;
            endcase
            ptr <= ptr + 2'd1;
          end else begin
            ptr <= '0;
          end
          if (cmd == CMD_RUN) begin
            step <= '0;
            path <= '0;
            if (n_paths_q == '0) out_q <= '0;
          end
        end
        ST_RUN: begin
          if (last_step) begin
            step <= '0;
            path <= path + 12'd1;
          end else begin
            step <= step + 1'b1;
          end
        end
        ST_DRAIN: if (bus.price_valid) out_q <= bus.price_in;
        default: ;
      endcase
    end
  end

  assign bus.s0      = s0_q;
  assign bus.strike  = strike_q;
  assign bus.sigma   = sigma_q;
  assign bus.n_paths = n_paths_q;
  assign bus.out     = out_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed self-checking bench for mc_sequencer with N_STEP=4.
module tb_mc_sequencer;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mc_sequencer_if bus ();

  mc_sequencer #(.N_STEP(4), .STEP_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic sst, input logic sv,
                             input logic pf, input logic pl, input logic bsy, input logic dn);
    chk({tag, ".sobol_start"}, 16'(bus.sobol_start), 16'(sst));
    chk({tag, ".step_valid"},  16'(bus.step_valid),  16'(sv));
    chk({tag, ".path_first"},  16'(bus.path_first),  16'(pf));
    chk({tag, ".path_last"},   16'(bus.path_last),   16'(pl));
    chk({tag, ".busy"},        16'(bus.busy),        16'(bsy));
    chk({tag, ".done"},        16'(bus.done),        16'(dn));
  endtask

  task automatic load4(input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input logic [11:0] d);
    bus.state = 2'b01; bus.in = a; tick();
    bus.in = b; tick();
    bus.in = c; tick();
    bus.in = d; tick();
    bus.state = 2'b00; bus.in = '0; tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.state = 2'b00;
    bus.in = '0;
    bus.price_in = '0;
    bus.price_valid = 1'b0;
    tick();
    tick();

    // reset state
    chk_strobes("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.s0", 16'(bus.s0), 16'd0);
    chk("rst.n_paths", 16'(bus.n_paths), 16'd0);
    chk("rst.out", bus.out, 16'd0);
    rst_n = 1'b1;
    tick();

    // parameter load
    load4(12'd100, 12'd200, 12'd300, 12'd3);
    chk("load.s0", 16'(bus.s0), 16'd100);
    chk("load.strike", 16'(bus.strike), 16'd200);
    chk("load.sigma", 16'(bus.sigma), 16'd300);
    chk("load.n_paths", 16'(bus.n_paths), 16'd3);
    chk_strobes("load", 0, 0, 0, 0, 0, 0);
    chk("load.out", bus.out, 16'd0);

    // full run with ignored commands and spurious price_valid
    bus.state = 2'b10; tick();
    chk_strobes("seed", 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 12; k++) begin
      if (k < 4) begin
        bus.state = 2'b01; bus.in = 12'd999;
        bus.price_valid = 1'b1; bus.price_in = 16'hFFFF;
      end else if (k < 8) begin
        bus.state = 2'b10; bus.price_valid = 1'b0;
      end else begin
        bus.state = 2'b00; bus.price_valid = 1'b0;
      end
      tick();
      chk_strobes($sformatf("run%0d", k), 0, 1, (k % 4) == 0, (k % 4) == 3, 1, 0);
    end
    bus.state = 2'b00; bus.in = '0; bus.price_valid = 1'b0;
    for (int d = 0; d < 5; d++) begin
      tick();
      chk_strobes($sformatf("drain%0d", d), 0, 0, 0, 0, 1, 0);
    end
    chk("ign.s0", 16'(bus.s0), 16'd100);
    chk("ign.n_paths", 16'(bus.n_paths), 16'd3);
    chk("ign.out", bus.out, 16'd0);
    bus.price_valid = 1'b1; bus.price_in = 16'h1234;
    tick();
    bus.price_valid = 1'b0; bus.price_in = '0;
    chk_strobes("done", 0, 0, 0, 0, 0, 1);
    chk("done.out", bus.out, 16'h1234);
    bus.state = 2'b10;            // RUN held in DONE must not retrigger
    tick();
    chk_strobes("done_hold", 0, 0, 0, 0, 0, 1);
    chk("done_hold.out", bus.out, 16'h1234);
    bus.state = 2'b00;
    tick();
    chk_strobes("idle", 0, 0, 0, 0, 0, 0);
    chk("idle.out", bus.out, 16'h1234);

    // zero paths
    load4(12'd10, 12'd20, 12'd30, 12'd0);
    chk("zero.n_paths", 16'(bus.n_paths), 16'd0);
    bus.state = 2'b10; tick();
    chk_strobes("zero", 0, 0, 0, 0, 0, 1);
    chk("zero.out", bus.out, 16'd0);
    bus.state = 2'b00; tick();
    chk("zero_idle.done", 16'(bus.done), 16'd0);

    // LOAD pointer wrap and clear
    bus.state = 2'b01;
    for (int v = 1; v <= 5; v++) begin
      bus.in = 12'(v);
      tick();
    end
    bus.state = 2'b00; tick();
    chk("wrap.s0", 16'(bus.s0), 16'd5);
    chk("wrap.strike", 16'(bus.strike), 16'd2);
    chk("wrap.n_paths", 16'(bus.n_paths), 16'd4);
    bus.state = 2'b01; bus.in = 12'd1; tick();
    bus.state = 2'b00; tick();
    bus.state = 2'b01; bus.in = 12'd7; tick();
    bus.state = 2'b00; tick();
    chk("clr.s0", 16'(bus.s0), 16'd7);
    chk("clr.strike", 16'(bus.strike), 16'd2);

    // reset mid-run at path 1 step 2
    bus.state = 2'b10; tick();
    bus.state = 2'b00;
    for (int k = 0; k < 7; k++) tick();
    chk_strobes("pre_rst", 0, 1, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk_strobes("mid_rst", 0, 0, 0, 0, 0, 0);
    chk("mid_rst.s0", 16'(bus.s0), 16'd0);
    chk("mid_rst.n_paths", 16'(bus.n_paths), 16'd0);
    chk("mid_rst.out", bus.out, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // fresh single-path run after reset
    load4(12'd100, 12'd200, 12'd300, 12'd1);
    bus.state = 2'b10; tick();
    bus.state = 2'b00;
    chk_strobes("r2.seed", 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_strobes($sformatf("r2.run%0d", k), 0, 1, k == 0, k == 3, 1, 0);
    end
    tick();
    chk_strobes("r2.drain", 0, 0, 0, 0, 1, 0);
    bus.price_valid = 1'b1; bus.price_in = 16'hABCD;
    tick();
    bus.price_valid = 1'b0;
    chk_strobes("r2.done", 0, 0, 0, 0, 0, 1);
    chk("r2.out", bus.out, 16'hABCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
